// File: rtl/lcm_pkg.sv
// lcm_pkg: shared state encoding and default datapath width for the LCM stage.
package lcm_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per step, MSB first.
// o_done pulses during the step that produces the final quotient bit.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_sh;
    logic             w_ge;
    // Dividend bits are shifted out of the quotient register as quotient bits shift in.
    assign w_sh        = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_ge        = r_rem[WIDTH] || (w_sh >= {1'b0, r_div});
    assign o_done      = i_step && r_cnt == '0;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem[WIDTH-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= CW'(WIDTH - 1);
        end else if (i_step) begin
            r_rem <= w_ge ? w_sh - {1'b0, r_div} : w_sh;
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/lcm_from_gcd.sv
// lcm_from_gcd: LCM = (num1 / gcd) * num2 via sequential divide then shift-add multiply.
// Define LCM_REM_CHECK_EN to also flag err when gcd_in does not divide num1.
module lcm_from_gcd
    import lcm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic [WIDTH-1:0]   gcd_in,
    input  logic               gcd_done,
    output logic [2*WIDTH-1:0] lcm_out,
    output logic               lcm_valid,
    output logic               busy,
    output logic               err
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    state_t             r_state;
    state_t             w_next;
    logic               r_done_q;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_lcm;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_k;
    logic               r_valid;
    logic               r_err;
    logic               w_start;
    logic               w_accept;
    logic               w_zero;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_quo;
`ifdef LCM_REM_CHECK_EN
    logic [WIDTH-1:0]   w_rem;
`else
    logic [WIDTH-1:0]   w_rem_unused;
`endif
    assign w_start    = gcd_done & ~r_done_q;
    assign w_accept   = w_start && (r_state == IDLE || r_state == DONE);
    assign w_zero     = gcd_in == '0;
    // Multiplier bits are consumed LSB first while the counter runs down.
    assign w_k        = CW'(WIDTH - 1) - r_cnt;
    assign w_acc_next = w_quo[w_k] ? r_acc + r_mcand : r_acc;
    assign lcm_out    = r_lcm;
    assign lcm_valid  = r_valid;
    assign err        = r_err;
    assign busy       = r_state == DIV || r_state == MUL;
    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept && !w_zero),
        .i_step     (r_state == DIV),
        .i_dividend (num1),
        .i_divisor  (gcd_in),
        .o_quotient (w_quo),
`ifdef LCM_REM_CHECK_EN
        .o_remainder(w_rem),
`else
        .o_remainder(w_rem_unused),
`endif
        .o_done     (w_div_done)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = w_accept                            ? (w_zero ? DONE : DIV) :
                 (r_state == DIV && w_div_done)      ? MUL :
                 (r_state == MUL && r_cnt == '0)     ? DONE : r_state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done_q <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_lcm    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done_q <= gcd_done;
            if (w_accept) begin
                r_valid <= w_zero;
                r_err   <= w_zero;
                if (w_zero) r_lcm <= '0;
                r_acc   <= '0;
                r_mcand <= {{WIDTH{1'b0}}, num2};
                r_cnt   <= CW'(WIDTH - 1);
            end else if (r_state == DIV) begin
                if (w_div_done) r_cnt <= CW'(WIDTH - 1);
            end else if (r_state == MUL) begin
                r_acc   <= w_acc_next;
                r_mcand <= r_mcand << 1;
                r_cnt   <= r_cnt - 1'b1;
`ifdef LCM_REM_CHECK_EN
                // First MUL cycle sees the divider's final remainder.
                if (r_cnt == CW'(WIDTH - 1) && w_rem != '0) r_err <= 1'b1;
`endif
                if (r_cnt == '0) begin
                    r_lcm   <= w_acc_next;
                    r_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcm_from_gcd.sv
// tb_lcm_from_gcd: table-driven scoreboard bench for lcm_from_gcd.
// Latency is counted in rising edges from the raise of gcd_done, the capture edge being 1.
module tb_lcm_from_gcd;
    localparam int W   = 32;
    localparam int LAT = 2 * W + 1;
`ifdef LCM_REM_CHECK_EN
    localparam logic REM_ERR = 1'b1;
`else
    localparam logic REM_ERR = 1'b0;
`endif
    typedef struct {
        logic [W-1:0]   n1;
        logic [W-1:0]   n2;
        logic [W-1:0]   g;
        logic [2*W-1:0] lcm;
        logic           err;
        int             edges;
    } vec_t;
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           gcd_done = 1'b0;
    logic [W-1:0]   num1 = '0;
    logic [W-1:0]   num2 = '0;
    logic [W-1:0]   gcd_in = '0;
    logic [2*W-1:0] lcm_out;
    logic           lcm_valid;
    logic           busy;
    logic           err;
    int             n_tests = 0;
    int             n_fail = 0;
    vec_t           tbl[8];
    vec_t           sb[$];
    always #5 clk = ~clk;
    lcm_from_gcd #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .num1     (num1),
        .num2     (num2),
        .gcd_in   (gcd_in),
        .gcd_done (gcd_done),
        .lcm_out  (lcm_out),
        .lcm_valid(lcm_valid),
        .busy     (busy),
        .err      (err)
    );
    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic [W-1:0] n1, input logic [W-1:0] n2, input logic [W-1:0] g,
                                input logic [2*W-1:0] lcm, input logic e, input int edges);
        vec_t v;
        v.n1 = n1; v.n2 = n2; v.g = g; v.lcm = lcm; v.err = e; v.edges = edges;
        return v;
    endfunction
    task automatic start_job(input logic [W-1:0] n1, input logic [W-1:0] n2, input logic [W-1:0] g);
        @(negedge clk);
        gcd_done = 1'b0;
        @(negedge clk);
        num1 = n1; num2 = n2; gcd_in = g;
        gcd_done = 1'b1;
    endtask
    task automatic finish_job(input string name, input int pre);
        vec_t e;
        int   n;
        n = pre;
        e = sb.pop_front();
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!lcm_valid && n < 300);
        chk({name, " latency"}, 64'(n), 64'(e.edges));
        chk({name, " lcm"}, lcm_out, e.lcm);
        chk({name, " err"}, 64'(err), 64'(e.err));
        chk({name, " busy"}, 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk({name, " hold valid"}, 64'(lcm_valid), 64'(1));
        chk({name, " hold busy"}, 64'(busy), 64'(0));
        chk({name, " hold lcm"}, lcm_out, e.lcm);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tbl[0] = mk(32'd12, 32'd18, 32'd6, 64'd36, 1'b0, LAT);
        tbl[1] = mk(32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 64'hFFFFFFFD00000002, 1'b0, LAT);
        tbl[2] = mk(32'd0, 32'd0, 32'd0, 64'd0, 1'b1, 1);
        tbl[3] = mk(32'd7, 32'd0, 32'd7, 64'd0, 1'b0, LAT);
        tbl[4] = mk(32'd10, 32'd4, 32'd3, 64'd12, REM_ERR, LAT);
        tbl[5] = mk(32'd0, 32'd5, 32'd5, 64'd0, 1'b0, LAT);
        tbl[6] = mk(32'h80000000, 32'd3, 32'h40000000, 64'd6, 1'b0, LAT);
        tbl[7] = mk(32'd1000, 32'd2000000, 32'd8, 64'd250000000, 1'b0, LAT);
        repeat (2) @(negedge clk);
        chk("reset lcm", lcm_out, 64'd0);
        chk("reset valid", 64'(lcm_valid), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset err", 64'(err), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(tbl[i]);
            start_job(tbl[i].n1, tbl[i].n2, tbl[i].g);
            finish_job($sformatf("vec%0d", i), 0);
        end
        // A start pulse arriving mid-job must be dropped.
        sb.push_back(mk(32'd21, 32'd6, 32'd3, 64'd42, 1'b0, LAT));
        start_job(32'd21, 32'd6, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        gcd_done = 1'b0;
        @(negedge clk);
        num1 = 32'd4; num2 = 32'd6; gcd_in = 32'd2;
        gcd_done = 1'b1;
        finish_job("ignored_pulse", 11);
        sb.push_back(mk(32'd4, 32'd6, 32'd2, 64'd12, 1'b0, LAT));
        start_job(32'd4, 32'd6, 32'd2);
        finish_job("after_ignored", 0);
        // Asynchronous reset in the middle of a job.
        start_job(32'd12, 32'd18, 32'd6);
        repeat (40) @(posedge clk);
        #1;
        chk("pre_reset busy", 64'(busy), 64'(1));
        reset = 1'b1;
        gcd_done = 1'b0;
        #1;
        chk("mid_reset lcm", lcm_out, 64'd0);
        chk("mid_reset valid", 64'(lcm_valid), 64'(0));
        chk("mid_reset busy", 64'(busy), 64'(0));
        chk("mid_reset err", 64'(err), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(mk(32'd12, 32'd18, 32'd6, 64'd36, 1'b0, LAT));
        start_job(32'd12, 32'd18, 32'd6);
        finish_job("after_reset", 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
